// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and helpers for the programmable sequence
//               detector: one-hot FSM state encoding, default pattern length
//               and the compare-mask builder.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int DEF_MAX_LEN = 8;

    // Mask builder width; callers size-cast the result down to MAX_LEN.
    localparam int MASK_W = 64;

    typedef enum logic [2:0] {
        DISABLED = 3'b001,
        FILL     = 3'b010,
        RUN      = 3'b100
    } state_t;

    // Mask with the low 'len' bits set.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            m[i] = (i < len);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_det_prog_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_prog_if
// Description : Configuration, serial-stream and result signals of the
//               programmable sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic               in_valid;
    logic               in_bit;
    logic               out;
    logic [CNT_W-1:0]   match_cnt;
    logic               cfg_err;

    modport master (
        output cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
        input  out, match_cnt, cfg_err
    );

    modport slave (
        input  cfg_load, cfg_pattern, cfg_len, cfg_overlap, in_valid, in_bit,
        output out, match_cnt, cfg_err
    );

endinterface
`default_nettype wire

// File: rtl/seq_det_prog_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int W = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         clr,
    input  wire logic         inc,
    output logic [W-1:0]      cnt
);

    // Count up on inc, clear wins over inc, never wrap past all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_prog
// Description : Runtime-programmable Mealy serial-pattern detector with
//               valid qualifier, overlap mode, saturating match counter and
//               configuration-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 8
) (
    input  wire logic        clk,
    input  wire logic        rst,
    seq_det_prog_if.slave    bus
);

    localparam int               LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

    state_t             state, state_nxt;
    logic [MAX_LEN-1:0] hist, hist_nxt;
    logic [LEN_W-1:0]   fill, fill_nxt;
    logic [MAX_LEN-1:0] pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;
    logic               err_q;

    logic               len_legal;
    logic [MAX_LEN-1:0] shifted;
    logic [MAX_LEN-1:0] mask;
    logic               hit;
    logic               last_fill;
    logic               match;

    assign len_legal = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_LEN_L);
    assign shifted   = {hist[MAX_LEN-2:0], bus.in_bit};
    assign mask      = MAX_LEN'(len_mask(int'(len_q)));
    assign hit       = ((shifted ^ pat_q) & mask) == '0;
    // The incoming bit completes the window when fill + 1 reaches len_q.
    assign last_fill = ({1'b0, fill} + {{LEN_W{1'b0}}, 1'b1}) >= {1'b0, len_q};
    // A load cycle discards the bit, so it can never produce a match.
    assign match     = !bus.cfg_load && bus.in_valid && hit &&
                       ((state == RUN) || ((state == FILL) && last_fill));

    assign bus.out     = match;
    assign bus.cfg_err = err_q;

    // FSM state and bit history registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DISABLED;
            hist  <= '0;
            fill  <= '0;
        end else begin
            state <= state_nxt;
            hist  <= hist_nxt;
            fill  <= fill_nxt;
        end
    end

    // Next state / history: load restarts, valid bits shift, non-overlap match clears.
    always_comb begin
        state_nxt = state;
        hist_nxt  = hist;
        fill_nxt  = fill;
        if (bus.cfg_load) begin
            hist_nxt  = '0;
            fill_nxt  = '0;
            state_nxt = len_legal ? FILL : DISABLED;
        end else if (bus.in_valid && (state != DISABLED)) begin
            if (match && !ovl_q) begin
                hist_nxt  = '0;
                fill_nxt  = '0;
                // A one-bit pattern is complete on every bit, so FILL is skipped.
                state_nxt = (len_q == ONE_L) ? RUN : FILL;
            end else begin
                hist_nxt = shifted;
                if (fill != MAX_LEN_L) begin
                    fill_nxt = fill + ONE_L;
                end
                if ((state == FILL) && last_fill) begin
                    state_nxt = RUN;
                end
            end
        end
    end

    // Configuration capture and error flag, updated only by a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            ovl_q <= 1'b0;
            err_q <= 1'b0;
        end else if (bus.cfg_load) begin
            pat_q <= bus.cfg_pattern;
            len_q <= bus.cfg_len;
            ovl_q <= bus.cfg_overlap;
            err_q <= !len_legal;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.cfg_load),
        .inc (match),
        .cnt (bus.match_cnt)
    );

endmodule
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_det_prog
// Description : Table-driven self-checking bench for seq_det_prog with a
//               scoreboard queue of expected out / match_cnt / cfg_err.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    typedef struct {
        logic       r;
        logic       ld;
        logic [7:0] pat;
        logic [3:0] len;
        logic       ovl;
        logic       v;
        logic       b;
        logic       eo;
        logic [1:0] ecnt;
        logic       eerr;
    } vec_t;

    typedef struct {
        logic       eo;
        logic [1:0] ecnt;
        logic       eerr;
        int         idx;
    } exp_t;

    logic clk;
    logic rst;
    vec_t tbl[$];
    exp_t sb[$];
    int   n_cmp;
    int   n_bad;
    logic [1:0] e_cnt;
    logic       e_err;

    seq_det_prog_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    seq_det_prog #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic ld, logic [7:0] pat, logic [3:0] len,
                                logic ovl, logic v, logic b, logic eo,
                                logic [1:0] ecnt, logic eerr);
        vec_t x;
        x.r = r; x.ld = ld; x.pat = pat; x.len = len; x.ovl = ovl;
        x.v = v; x.b = b; x.eo = eo; x.ecnt = ecnt; x.eerr = eerr;
        return x;
    endfunction

    // Valid bit with the expected Mealy output for that bit.
    function void add_bit(logic b, logic eo);
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b, eo, e_cnt, e_err));
        if (eo && (e_cnt != 2'd3)) e_cnt = e_cnt + 2'd1;
    endfunction

    function void add_bits(logic [15:0] bits, logic [15:0] outs, int n);
        for (int i = n - 1; i >= 0; i--) add_bit(bits[i], outs[i]);
    endfunction

    function void add_gap();
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, e_cnt, e_err));
    endfunction

    function void add_ld(logic [7:0] pat, logic [3:0] len, logic ovl, logic v, logic b);
        tbl.push_back(mk(1'b0, 1'b1, pat, len, ovl, v, b, 1'b0, e_cnt, e_err));
        e_cnt = 2'd0;
        e_err = (len == 4'd0) || (len > 4'd8);
    endfunction

    function void add_rst();
        e_cnt = 2'd0;
        e_err = 1'b0;
        tbl.push_back(mk(1'b1, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, e_cnt, e_err));
    endfunction

    // Compare every expectation in the cycle its inputs were applied.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            if (bus.out !== e.eo) begin
                n_bad++;
                $display("FAIL out row %0d: got %b expected %b", e.idx, bus.out, e.eo);
            end
            n_cmp++;
            if (bus.match_cnt !== e.ecnt) begin
                n_bad++;
                $display("FAIL match_cnt row %0d: got %0d expected %0d", e.idx, bus.match_cnt, e.ecnt);
            end
            n_cmp++;
            if (bus.cfg_err !== e.eerr) begin
                n_bad++;
                $display("FAIL cfg_err row %0d: got %b expected %b", e.idx, bus.cfg_err, e.eerr);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        e_cnt = 2'd0;
        e_err = 1'b0;
        rst   = 1'b1;
        bus.cfg_load = 1'b0; bus.cfg_pattern = '0; bus.cfg_len = '0;
        bus.cfg_overlap = 1'b0; bus.in_valid = 1'b0; bus.in_bit = 1'b0;

        // Reset state.
        add_rst();
        add_rst();
        // Bits before any load are ignored.
        add_bits(16'b11, 16'b00, 2);

        // 01011 overlapping: matches on bits 5 and 10.
        add_ld(8'h0B, 4'd5, 1'b1, 1'b0, 1'b0);
        add_bits(16'b0101101011, 16'b0000100001, 10);
        add_gap();

        // 0101 (upper pattern bits junk), overlap then non-overlap.
        add_ld(8'hA5, 4'd4, 1'b1, 1'b0, 1'b0);
        add_bits(16'b0101010, 16'b0001010, 7);
        add_ld(8'hA5, 4'd4, 1'b0, 1'b0, 1'b0);
        add_bits(16'b0101010, 16'b0001000, 7);
        add_gap();

        // 11: overlap matches on 2,3,4; non-overlap on 2,4.
        add_ld(8'hF3, 4'd2, 1'b1, 1'b0, 1'b0);
        add_bits(16'b1111, 16'b0111, 4);
        add_ld(8'hF3, 4'd2, 1'b0, 1'b0, 1'b0);
        add_bits(16'b1111, 16'b0101, 4);
        add_gap();

        // Invalid-bit gaps are transparent.
        add_ld(8'h0B, 4'd5, 1'b1, 1'b0, 1'b0);
        add_bits(16'b010, 16'b000, 3);
        add_gap(); add_gap(); add_gap();
        add_bits(16'b11, 16'b01, 2);
        // Reset mid-pattern aborts the partial match.
        add_ld(8'h0B, 4'd5, 1'b1, 1'b0, 1'b0);
        add_bits(16'b010, 16'b000, 3);
        add_rst();
        add_bits(16'b11, 16'b00, 2);

        // Illegal lengths flag an error and disable matching.
        add_ld(8'h0B, 4'd0, 1'b1, 1'b0, 1'b0);
        add_bits(16'b01011, 16'b00000, 5);
        add_ld(8'h0B, 4'd9, 1'b1, 1'b0, 1'b0);
        add_bits(16'b01011, 16'b00000, 5);
        // Legal load clears the error; a mid-pattern load discards its own bit.
        add_ld(8'h0B, 4'd5, 1'b1, 1'b0, 1'b0);
        add_bits(16'b01011010, 16'b00001000, 8);
        add_ld(8'h0B, 4'd5, 1'b1, 1'b1, 1'b1);
        add_bits(16'b1, 16'b0, 1);
        add_bits(16'b01011, 16'b00001, 5);
        // Illegal load while running drops back to disabled.
        add_ld(8'h0B, 4'd0, 1'b1, 1'b0, 1'b0);
        add_bits(16'b1011, 16'b0000, 4);

        // One-bit pattern, counter saturates at 3.
        add_ld(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        add_bits(16'b111111, 16'b111111, 6);
        add_gap();
        add_ld(8'hFF, 4'd1, 1'b0, 1'b0, 1'b0);
        add_bits(16'b1101, 16'b1101, 4);
        add_gap();

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst             = tbl[i].r;
            bus.cfg_load    = tbl[i].ld;
            bus.cfg_pattern = tbl[i].pat;
            bus.cfg_len     = tbl[i].len;
            bus.cfg_overlap = tbl[i].ovl;
            bus.in_valid    = tbl[i].v;
            bus.in_bit      = tbl[i].b;
            sb.push_back('{eo: tbl[i].eo, ecnt: tbl[i].ecnt, eerr: tbl[i].eerr, idx: i});
        end
        @(posedge clk);
        #1;
        bus.cfg_load = 1'b0;
        bus.in_valid = 1'b0;
        for (int k = 0; k < 4 && sb.size() != 0; k++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_det_prog.md
Name: seq_det_prog

Overview:
Runtime-programmable Mealy serial-pattern detector. Successor to the fixed 01011 detector.
- Pattern (up to MAX_LEN bits), active length and overlap mode are loaded at runtime.
- Adds an input-valid qualifier, a saturating match counter and a configuration-error flag.
- Sits on a serial bit stream; downstream logic consumes the single-cycle match pulse and the counter.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, match counter width in bits
LEN_W, $clog2(MAX_LEN+1), width of the length field (derived; not for override)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
cfg_load  in  1  one-cycle strobe; latches cfg_pattern, cfg_len and cfg_overlap
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is received first, bit [0] is received last
cfg_len  in  LEN_W  active pattern length, legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history cleared after each match
in_valid  in  1  qualifies in_bit
in_bit  in  1  serial data bit
out  out  1  Mealy match pulse, combinational from the current bit and the stored history
match_cnt  out  CNT_W  registered count of matches; saturates at all-ones
cfg_err  out  1  registered flag; set when the last load had cfg_len of 0 or greater than MAX_LEN

Behaviour:
Reset values:
- state = DISABLED; hist = 0; fill = 0; pattern, length and overlap registers = 0.
- match_cnt = 0; cfg_err = 0; out = 0.
- Reset asserted mid-stream aborts any partial match immediately.

Register fields:
- hist: MAX_LEN-bit shift register holding the most recent bits.
- fill: valid-bit count, saturating at MAX_LEN.

FSM states: DISABLED, FILL, RUN.
- DISABLED: out = 0; bits are ignored.
  - cfg_load with a legal length goes to FILL.
  - cfg_load with an illegal length stays in DISABLED and sets cfg_err.
- FILL: fill + 1 < len_q. Each valid bit shifts into hist and increments fill.
  - The transition to RUN occurs when the incoming valid bit makes fill + 1 >= len_q.
  - The match check applies on that same bit.
- RUN: match condition is in_valid AND (low len_q bits of {hist, in_bit} == low len_q bits of pat_q).
  - out equals the match condition in the same cycle (Mealy; zero latency).
  - On a match, match_cnt increments on the next edge unless it is all-ones.
  - Overlap = 1 on a match: shift normally and stay in RUN.
  - Overlap = 0 on a match: clear hist and set fill to 0 on the next edge, then return to FILL.
  - When len_q = 1, the FSM never returns to FILL; every valid matching bit pulses out.

General rules:
- in_valid = 0: no shift, no count change, out = 0, state held. Gaps are transparent to matching.
- cfg_load in any state:
  - Clears hist, fill and match_cnt.
  - Updates cfg_err.
  - Sets the next state to FILL (legal length) or DISABLED (illegal length).
  - A bit presented with in_valid in the same cycle is discarded, and out = 0 that cycle.
- cfg_err stays set until the next legal cfg_load or reset.
- Only the low len_q bits of pat_q and hist are compared; upper bits are don't-care.
- Match counter saturates; it does not wrap.

Decomposition:
- Package seq_det_pkg contains:
  - the state enum typedef (DISABLED, FILL, RUN), one-hot encoded;
  - a localparam default MAX_LEN;
  - the function len_mask(len), which returns a MAX_LEN-bit mask with the low len bits set.
- One sub-module, sat_counter, with parameter W, inputs clk, rst, clr and inc, and output cnt. Used for match_cnt.
- The FSM and the compare logic stay in seq_det_prog.

Test Plan:
1. Load pattern 5'b01011, len 5, overlap 1; stream 0,1,0,1,1,0,1,0,1,1 -> out high on bits 5 and 10 only; match_cnt = 2.
2. Load pattern 4'b0101, len 4; stream 0,1,0,1,0,1,0 -> with overlap = 1, out on bits 4 and 6, match_cnt = 2; with overlap = 0, out on bit 4 only, match_cnt = 1.
3. Load pattern 2'b11, len 2; stream 1,1,1,1 -> with overlap = 1, out on bits 2, 3 and 4; with overlap = 0, out on bits 2 and 4.
4. Pattern 01011, with in_valid low for 3 cycles between bits 3 and 4 -> match still on the fifth valid bit. Then assert rst after bits 0,1,0 -> no match from the following 1,1; outputs at 0 during reset.
5. cfg_len = 0 or MAX_LEN+1 -> cfg_err = 1 and out never asserts. A subsequent legal load -> cfg_err = 0. A cfg_load mid-pattern discards the partial match and clears match_cnt.
6. CNT_W = 2, len 1, pattern 1, six valid 1s -> out high on all six; match_cnt = 3 (saturated).
